// File: rtl/parity_sequencer_if.sv
// Byte-in / result-out handshake bundle for parity_sequencer.
// The slave view belongs to the sequencer. The master view belongs to whatever
// feeds it bytes and consumes its parity results.
interface parity_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] D;
  logic       even;
  logic [3:0] exp;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] P;
  logic       err;

  modport slave (
    input  in_valid, D, even, exp, out_ready,
    output in_ready, out_valid, P, err
  );

  modport master (
    output in_valid, D, even, exp, out_ready,
    input  in_ready, out_valid, P, err
  );
endinterface

// File: rtl/parity_sequencer.sv
// parity_sequencer: accepts one byte and steps an external 4-mode parity unit
// through modes 0..3, one mode per cycle. It collects the four parity bits into
// P, compares P with the expected vector, and keeps a saturating count of
// mismatching bytes.
module parity_sequencer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  parity_sequencer_if.slave bus,
  output logic [7:0]        pu_D,
  output logic [1:0]        pu_chk,
  output logic              pu_even,
  input  logic              pu_Y,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              clr_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] idx;
  logic [3:0] exp_q;
  logic [3:0] p_q;
  logic       err_q;
  logic       accept;
  logic       last_scan;
  logic       release_done;
  logic [3:0] p_final;
  logic       mismatch;

  // State register; reset returns to IDLE from any state, dropping a byte in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, handshake outputs and parity-unit mode select.
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    last_scan    = 1'b0;
    release_done = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    pu_chk       = 2'd0;
    case (state)
      IDLE: begin
        bus.in_ready = ~rst;
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        pu_chk = idx;
        if (idx == 2'd3) begin
          last_scan = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          release_done = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Complete parity vector as it will look after the final capture. The
  // result is then available on the same edge that enters DONE.
  always_comb begin
    p_final  = {pu_Y, p_q[2:0]};
    mismatch = (p_final != exp_q);
  end

  // Byte latch, parity capture and registered mismatch flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= 2'd0;
      exp_q   <= '0;
      p_q     <= '0;
      pu_D    <= '0;
      pu_even <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        pu_D    <= bus.D;
        pu_even <= bus.even;
        exp_q   <= bus.exp;
        p_q     <= '0;
        idx     <= 2'd0;
      end
      if (state == SCAN) begin
        p_q[idx] <= pu_Y;
        idx      <= idx + 2'd1;
      end
      if (last_scan) begin
        err_q <= mismatch;
      end
      if (release_done) begin
        err_q <= 1'b0;
      end
    end
  end

  // Saturating mismatch counter; a clear beats a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      err_cnt <= '0;
    end else if (last_scan && mismatch && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  assign bus.P   = p_q;
  assign bus.err = err_q;

endmodule

// File: tb/tb_parity_sequencer.sv
// Directed bench for parity_sequencer. It models the external 4-mode parity
// unit and checks the handshake timing, the parity collection, the mismatch
// flag, counter saturation and clear, and reset mid-scan.
module tb_parity_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] pu_D;
  logic [1:0] pu_chk;
  logic       pu_even;
  logic       pu_Y;
  logic [7:0] err_cnt;
  logic       clr_cnt;
  int         checks;
  int         fails;
  int         cyc;

  parity_sequencer_if bus ();

  parity_sequencer #(.CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .pu_D    (pu_D),
    .pu_chk  (pu_chk),
    .pu_even (pu_even),
    .pu_Y    (pu_Y),
    .err_cnt (err_cnt),
    .clr_cnt (clr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model of the external parity unit.
  always_comb begin
    case (pu_chk)
      2'd0:    pu_Y = (^(pu_D & 8'hF0)) ^ pu_even;
      2'd1:    pu_Y = (^(pu_D & 8'h55)) ^ pu_even;
      2'd2:    pu_Y = (^(pu_D & 8'hAA)) ^ pu_even;
      default: pu_Y = (^pu_D) ^ pu_even;
    endcase
  end

  function automatic logic [3:0] model_p(input logic [7:0] d, input logic e);
    logic [3:0] r;
    r[0] = ^(d & 8'hF0);
    r[1] = ^(d & 8'h55);
    r[2] = ^(d & 8'hAA);
    r[3] = ^d;
    return r ^ {4{e}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Run one full transaction with out_ready asserted in DONE.
  task automatic run_byte(input logic [7:0] d, input logic e, input logic [3:0] x);
    int n;
    bus.in_valid = 1'b1;
    bus.D        = d;
    bus.even     = e;
    bus.exp      = x;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("run_ready_timeout", 32'(n), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("run_valid_timeout", 32'(n), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  logic [7:0] vec_d [4];
  logic       vec_e [4];
  logic [3:0] exp_p;
  int         n;
  int         acc;
  int         prev;

  initial begin
    checks = 0;
    fails  = 0;
    vec_d  = '{8'h3C, 8'hB7, 8'h80, 8'h5A};
    vec_e  = '{1'b0, 1'b1, 1'b0, 1'b1};
    rst           = 1'b1;
    clr_cnt       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.D         = 8'h00;
    bus.even      = 1'b0;
    bus.exp       = 4'h0;

    // Reset state.
    tick();
    tick();
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_P", bus.P, 4'h0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_err_cnt", err_cnt, 8'd0);
    chk("rst_pu_D", pu_D, 8'h00);
    chk("rst_pu_chk", pu_chk, 2'd0);
    chk("rst_pu_even", pu_even, 1'b0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", bus.in_ready, 1'b1);

    // A5, even form, expect F: match.
    bus.in_valid = 1'b1;
    bus.D        = 8'hA5;
    bus.even     = 1'b1;
    bus.exp      = 4'hF;
    tick();
    bus.in_valid = 1'b0;
    chk("t1_in_ready_scan", bus.in_ready, 1'b0);
    chk("t1_pu_D", pu_D, 8'hA5);
    chk("t1_pu_even", pu_even, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t1_no_early_valid", bus.out_valid, 1'b0);
    end
    tick();
    chk("t1_out_valid_lat4", bus.out_valid, 1'b1);
    chk("t1_P", bus.P, 4'hF);
    chk("t1_err", bus.err, 1'b0);
    chk("t1_err_cnt", err_cnt, 8'd0);
    chk("t1_pu_chk_done", pu_chk, 2'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("t1_idle_out_valid", bus.out_valid, 1'b0);
    chk("t1_idle_in_ready", bus.in_ready, 1'b1);
    chk("t1_idle_err", bus.err, 1'b0);

    // 01, odd form, expect 0: mismatch; pu_chk must sequence 0..3.
    bus.in_valid = 1'b1;
    bus.D        = 8'h01;
    bus.even     = 1'b0;
    bus.exp      = 4'h0;
    tick();
    bus.in_valid = 1'b0;
    bus.D        = 8'hFF;
    chk("t2_pu_chk0", pu_chk, 2'd0);
    tick();
    chk("t2_pu_chk1", pu_chk, 2'd1);
    tick();
    chk("t2_pu_chk2", pu_chk, 2'd2);
    tick();
    chk("t2_pu_chk3", pu_chk, 2'd3);
    chk("t2_pu_D_held", pu_D, 8'h01);
    tick();
    chk("t2_out_valid", bus.out_valid, 1'b1);
    chk("t2_P", bus.P, 4'b1010);
    chk("t2_err", bus.err, 1'b1);
    chk("t2_err_cnt", err_cnt, 8'd1);

    // Hold in DONE for 10 cycles with out_ready low and a stray in_valid.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold_P", bus.P, 4'b1010);
      chk("t3_hold_err", bus.err, 1'b1);
      chk("t3_hold_in_ready", bus.in_ready, 1'b0);
      chk("t3_hold_out_valid", bus.out_valid, 1'b1);
    end
    chk("t3_pu_D_held", pu_D, 8'h01);
    chk("t3_err_cnt", err_cnt, 8'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("t3_release_out_valid", bus.out_valid, 1'b0);
    chk("t3_release_in_ready", bus.in_ready, 1'b1);
    chk("t3_release_err", bus.err, 1'b0);

    // Back-to-back bytes with in_valid and out_ready held high.
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.exp       = 4'h0;
    bus.D         = vec_d[0];
    bus.even      = vec_e[0];
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!bus.in_ready && n < 20) begin
        tick();
        n++;
      end
      chk("b2b_ready_wait", 32'(n < 20), 32'd1);
      tick();
      acc = cyc;
      if (i > 0) chk("b2b_spacing", 32'(acc - prev), 32'd6);
      prev  = acc;
      exp_p = model_p(vec_d[i], vec_e[i]);
      if (i < 3) begin
        bus.D    = vec_d[i + 1];
        bus.even = vec_e[i + 1];
      end
      n = 0;
      while (!bus.out_valid && n < 20) begin
        tick();
        n++;
      end
      chk("b2b_latency", 32'(n), 32'd4);
      chk("b2b_P", bus.P, exp_p);
      chk("b2b_err", bus.err, exp_p != 4'h0);
    end
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;

    // Clear, then drive the counter to saturation with mismatching bytes.
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_err_cnt", err_cnt, 8'd0);
    for (int i = 0; i < 253; i++) run_byte(8'h01, 1'b0, 4'h0);
    chk("sat_253", err_cnt, 8'd253);
    run_byte(8'h01, 1'b0, 4'h0);
    chk("sat_254", err_cnt, 8'd254);
    run_byte(8'h01, 1'b0, 4'h0);
    chk("sat_255", err_cnt, 8'd255);
    run_byte(8'h01, 1'b0, 4'h0);
    chk("sat_hold_255", err_cnt, 8'd255);

    // clr_cnt on the same edge as a mismatch increment.
    bus.in_valid = 1'b1;
    bus.D        = 8'h01;
    bus.even     = 1'b0;
    bus.exp      = 4'h0;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("clrinc_pu_chk3", pu_chk, 2'd3);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clrinc_err_cnt", err_cnt, 8'd0);
    chk("clrinc_err", bus.err, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Reset in SCAN at idx 2 drops the byte.
    bus.in_valid = 1'b1;
    bus.D        = 8'hC3;
    bus.even     = 1'b1;
    bus.exp      = 4'h0;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("midrst_idx2", pu_chk, 2'd2);
    rst = 1'b1;
    tick();
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_P", bus.P, 4'h0);
    chk("midrst_pu_chk", pu_chk, 2'd0);
    chk("midrst_pu_D", pu_D, 8'h00);
    chk("midrst_in_ready_held", bus.in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid) n++;
    end
    chk("midrst_no_result", 32'(n), 32'd0);
    bus.out_ready = 1'b0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/parity_sequencer.md
PARITY_SEQUENCER -- requirements
Module: parity_sequencer

Interface
REQ-001 Parameter: CNT_W, 8, width of the saturating mismatch counter err_cnt.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  upstream byte available.
REQ-005 Port: in_ready  output  1  block can accept a byte.
REQ-006 Port: D  input  8  data byte to check.
REQ-007 Port: even  input  1  parity sense for this byte (1 = inverted/even form), sampled with D.
REQ-008 Port: exp  input  4  expected parity vector, sampled with D.
REQ-009 Port: pu_D  output  8  byte driven to the external 4-mode parity unit.
REQ-010 Port: pu_chk  output  2  mode select to the parity unit (0 hi-nibble, 1 even bits, 2 odd bits, 3 all bits).
REQ-011 Port: pu_even  output  1  parity sense to the parity unit.
REQ-012 Port: pu_Y  input  1  combinational parity result from the parity unit.
REQ-013 Port: out_valid  output  1  result vector valid.
REQ-014 Port: out_ready  input  1  downstream accepts result.
REQ-015 Port: P  output  4  collected parities, P[k] = pu_Y sampled with pu_chk = k.
REQ-016 Port: err  output  1  P != latched exp; valid while out_valid.
REQ-017 Port: err_cnt  output  CNT_W  saturating count of mismatching bytes.
REQ-018 Port: clr_cnt  input  1  synchronous clear of err_cnt.

Function
REQ-019 The FSM SHALL have states IDLE, SCAN, DONE; in_ready = 1 only in IDLE (and 0 while rst is high).
REQ-020 IDLE: on in_valid && in_ready at an edge, the block SHALL latch D, even and exp, clear P, set idx = 0 and enter SCAN; otherwise it SHALL remain in IDLE.
REQ-021 SCAN: the block SHALL drive pu_chk = idx, pu_D = latched D, pu_even = latched even; at each edge it SHALL capture P[idx] <= pu_Y and increment idx.
REQ-022 After capturing idx = 3, the block SHALL enter DONE; no early exit from SCAN.
REQ-023 In IDLE and DONE, pu_chk SHALL be 0, and pu_D/pu_even SHALL hold the last latched values (0 after reset).
REQ-024 DONE: out_valid = 1; P and err SHALL stay stable until out_ready = 1 at an edge, then return to IDLE.
REQ-025 Latency: out_valid SHALL rise exactly 4 cycles after the accepting edge. Minimum spacing between accepts is 6 cycles when out_ready is held at 1.
REQ-026 err SHALL be registered on the SCAN->DONE edge as (final P != latched exp), and SHALL be 0 outside DONE.
REQ-027 err_cnt SHALL increment by 1 on the SCAN->DONE edge when the result mismatches, and SHALL saturate at 2^CNT_W-1.
REQ-028 clr_cnt SHALL set err_cnt to 0 at the next edge; when clr_cnt coincides with an increment, the clear wins (err_cnt = 0).
REQ-029 in_valid SHALL be ignored in SCAN and DONE; inputs D, even and exp SHALL be ignored except at the accepting edge.
REQ-030 out_ready SHALL be ignored outside DONE.

Reset
REQ-031 While rst = 1 at an edge, the block SHALL enter IDLE with P = 0, err = 0, err_cnt = 0, out_valid = 0, idx = 0, pu_D = 0, pu_chk = 0 and pu_even = 0, regardless of state.
REQ-032 Reset asserted mid-SCAN or in DONE SHALL discard the byte in flight; no out_valid pulse SHALL follow.
REQ-033 in_ready SHALL be 1 on the first cycle after rst is deasserted.

Verification
REQ-034 The bench SHALL cover: D=8'hA5, even=1, exp=4'hF -> out_valid 4 cycles after accept, P=4'b1111, err=0, err_cnt unchanged.
REQ-035 The bench SHALL cover: D=8'h01, even=0, exp=4'b0000 -> P=4'b1010, err=1, err_cnt +1; pu_chk observed as 0,1,2,3 on consecutive SCAN cycles.
REQ-036 The bench SHALL cover: out_ready held 0 for 10 cycles in DONE -> P and err stable, in_ready=0, a new in_valid ignored; on out_ready=1 -> IDLE next cycle.
REQ-037 The bench SHALL cover: a forced err_cnt near saturation (CNT_W=8) followed by 3 mismatching bytes -> err_cnt stops at 255; then clr_cnt coinciding with a mismatch -> err_cnt = 0.
REQ-038 The bench SHALL cover: rst asserted in SCAN with idx=2 -> next cycle IDLE, P=0, out_valid=0, in_ready=1 after release, and no result emitted.
REQ-039 The bench SHALL cover: back-to-back bytes with in_valid and out_ready held at 1 -> accepts exactly 6 cycles apart, each P matching a software model of the 4 parity modes.
